// File: rtl/mult_dispatcher_if.sv
// Handshake bundle around mult_dispatcher: producer, multiplier and consumer channels.
// Latency: none, wiring only.
// Backpressure: op_ready throttles the producer, res_accept holds results, mul_ready stalls issue.
// Ports: op_valid/op_a/op_b/op_ready   operand pair channel from the producer
//        mul_start/mul_in_1/mul_in_2   issue side of the 4x4 sequential multiplier
//        mul_out/mul_ready             completion side of the multiplier
//        res_valid/res_data/res_accept product channel to the consumer
//        pending/err                   FIFO occupancy and sticky product-check error
// slave modport is the dispatcher; master modport is the environment around it.
interface mult_dispatcher_if #(
  parameter int PW = 3
);
  logic          op_valid;
  logic [3:0]    op_a;
  logic [3:0]    op_b;
  logic          op_ready;
  logic          mul_start;
  logic [3:0]    mul_in_1;
  logic [3:0]    mul_in_2;
  logic [7:0]    mul_out;
  logic          mul_ready;
  logic          res_valid;
  logic [7:0]    res_data;
  logic          res_accept;
  logic [PW-1:0] pending;
  logic          err;

  modport slave (
    input  op_valid, op_a, op_b, mul_out, mul_ready, res_accept,
    output op_ready, mul_start, mul_in_1, mul_in_2, res_valid, res_data, pending, err
  );

  modport master (
    output op_valid, op_a, op_b, mul_out, mul_ready, res_accept,
    input  op_ready, mul_start, mul_in_1, mul_in_2, res_valid, res_data, pending, err
  );
endinterface

// File: rtl/mult_dispatcher.sv
// Operand FIFO feeding a 4x4 sequential multiplier one pair at a time, returning 8-bit products.
// Latency: pop one edge after push into an empty FIFO, start pulse the next cycle, result the edge after mul_ready returns.
// Backpressure: op_ready drops when the FIFO is full; results are held in HOLD until res_accept.
// Ports: clk, rst (async, active-low) plus bus (mult_dispatcher_if.slave) carrying the
//        op_*, mul_*, res_*, pending and err signals.
// Optional: define MULT_DISPATCH_CHECK_EN to build the product checker driving a sticky err;
//           otherwise err is tied low.
module mult_dispatcher #(
  parameter int DEPTH = 4,
  parameter int PW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  mult_dispatcher_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_HOLD      = 3'd4;

  logic [2:0]    state;
  logic [3:0]    mem_a [DEPTH];
  logic [3:0]    mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic          not_full;
  logic          push;
  logic          pop;
  logic [3:0]    in_1;
  logic [3:0]    in_2;
  logic          res_vld;
  logic [7:0]    res_dat;

  // Push is gated by the pre-edge count only, so a full FIFO refuses a pair
  // even when the FSM pops in the same cycle.
  assign not_full = (count != PW'(DEPTH));
  assign push     = bus.op_valid && not_full;
  // Pop looks at the registered count, so a pair pushed into an empty FIFO
  // becomes visible to the FSM one cycle later.
  assign pop      = (state == S_IDLE) && (count != '0) && bus.mul_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.op_a;
      mem_b[wr_ptr] <= bus.op_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  // Operand registers load only on pop, so they stay frozen for the whole
  // busy period of the multiplier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      in_1    <= '0;
      in_2    <= '0;
      res_vld <= 1'b0;
      res_dat <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            in_1  <= mem_a[rd_ptr];
            in_2  <= mem_b[rd_ptr];
            state <= S_ISSUE;
          end
        end
        S_ISSUE:     state <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (!bus.mul_ready) state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (bus.mul_ready) begin
            res_dat <= bus.mul_out;
            res_vld <= 1'b1;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.res_accept) begin
            res_vld <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MULT_DISPATCH_CHECK_EN
  logic       err_q;
  logic [7:0] expect_prod;

  assign expect_prod = {4'd0, in_1} * {4'd0, in_2};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((state == S_WAIT_DONE) && bus.mul_ready && (bus.mul_out != expect_prod)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.op_ready  = not_full;
  assign bus.mul_start = (state == S_ISSUE);
  assign bus.mul_in_1  = in_1;
  assign bus.mul_in_2  = in_2;
  assign bus.res_valid = res_vld;
  assign bus.res_data  = res_dat;
  assign bus.pending   = count;
endmodule

// File: tb/tb_mult_dispatcher.sv
// Directed bench for mult_dispatcher with a behavioural 6-cycle multiplier model.
// Latency: n/a. Backpressure: exercised through res_accept and a full operand FIFO.
// Vector table for single pairs plus hand-written multi-cycle sequences.
module tb_mult_dispatcher;
`ifdef MULT_DISPATCH_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk;
  logic rst;

  mult_dispatcher_if #(.PW(3)) bus ();

  mult_dispatcher #(.DEPTH(4), .PW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: ready drops the cycle after start, rises 6 cycles later.
  logic       corrupt;
  int         mcnt;
  logic [7:0] mprod;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mul_ready <= 1'b1;
      bus.mul_out   <= 8'h00;
      mcnt          <= 0;
      mprod         <= 8'h00;
    end else if (bus.mul_start) begin
      bus.mul_ready <= 1'b0;
      mcnt          <= 6;
      mprod <= (corrupt && bus.mul_in_1 == 4'd3 && bus.mul_in_2 == 4'd3) ? 8'h00
               : ({4'd0, bus.mul_in_1} * {4'd0, bus.mul_in_2});
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        bus.mul_ready <= 1'b1;
        bus.mul_out   <= mprod;
      end
    end
  end

  // Start-pulse counter and operand stability watcher.
  int         n_starts;
  int         n_in_change;
  logic [3:0] last1;
  logic [3:0] last2;
  always @(posedge clk) begin
    if (bus.mul_start) n_starts <= n_starts + 1;
    if (!bus.mul_ready && (bus.mul_in_1 != last1 || bus.mul_in_2 != last2))
      n_in_change <= n_in_change + 1;
    last1 <= bus.mul_in_1;
    last2 <= bus.mul_in_2;
  end

  int n_chk;
  int n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    int t = 0;
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    while (!bus.op_ready && t < 100) begin
      tick();
      t++;
    end
    if (!bus.op_ready) begin
      n_chk++;
      $display("FAIL push_timeout: op_ready got 0, expected 1");
    end
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_res(input string name);
    int t = 0;
    while (!bus.res_valid && t < 60) begin
      tick();
      t++;
    end
    if (!bus.res_valid) begin
      n_chk++;
      $display("FAIL %s: res_valid timeout, got 0, expected 1", name);
    end
  endtask

  // Collect up to n results with res_accept held high; returns how many arrived.
  task automatic collect(input int n, output logic [7:0] q [8], output int got);
    got = 0;
    for (int t = 0; t < 300 && got < n; t++) begin
      if (bus.res_valid) begin
        q[got] = bus.res_data;
        got++;
      end
      tick();
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
  } vec_t;

  vec_t       vecs [5];
  logic [3:0] fill_a [6];
  logic [3:0] fill_b [6];
  logic [7:0] res_q [8];
  int         got;
  int         s0;
  int         v0;
  int         idx;
  logic       flag;

  initial begin
    vecs[0] = '{a: 4'd6,  b: 4'd9,  prod: 8'h36};
    vecs[1] = '{a: 4'd15, b: 4'd1,  prod: 8'h0F};
    vecs[2] = '{a: 4'd0,  b: 4'd13, prod: 8'h00};
    vecs[3] = '{a: 4'd15, b: 4'd15, prod: 8'hE1};
    vecs[4] = '{a: 4'd12, b: 4'd12, prod: 8'h90};
    fill_a  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    fill_b  = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};

    n_chk = 0; n_pass = 0; corrupt = 1'b0;
    rst = 1'b0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.res_accept = 1'b0;

    // Reset values while held in reset and on release.
    tick(); tick();
    check("rst_mul_start", bus.mul_start, 0);
    check("rst_mul_in_1",  bus.mul_in_1, 0);
    check("rst_mul_in_2",  bus.mul_in_2, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data",  bus.res_data, 0);
    check("rst_pending",   bus.pending, 0);
    check("rst_err",       bus.err, 0);
    check("rst_op_ready",  bus.op_ready, 1);
    rst = 1'b1;
    tick();
    check("rel_op_ready", bus.op_ready, 1);

    // Single pairs from the vector table.
    for (int i = 0; i < 5; i++) begin
      s0 = n_starts;
      push(vecs[i].a, vecs[i].b);
      wait_res($sformatf("vec%0d_wait", i));
      check($sformatf("vec%0d_res_data", i), bus.res_data, vecs[i].prod);
      check($sformatf("vec%0d_mul_in_1", i), bus.mul_in_1, vecs[i].a);
      check($sformatf("vec%0d_mul_in_2", i), bus.mul_in_2, vecs[i].b);
      check($sformatf("vec%0d_starts", i), n_starts - s0, 1);
      bus.res_accept = 1'b1;
      tick();
      bus.res_accept = 1'b0;
      check($sformatf("vec%0d_res_valid_clr", i), bus.res_valid, 0);
      check($sformatf("vec%0d_pending", i), bus.pending, 0);
    end
    check("vec_err", bus.err, 0);

    // Back-to-back pushes with results accepted immediately.
    bus.res_accept = 1'b1;
    s0 = n_starts;
    v0 = n_in_change;
    bus.op_valid = 1'b1;
    bus.op_a = 4'd10; bus.op_b = 4'd3;  tick();
    bus.op_a = 4'd11; bus.op_b = 4'd5;  tick();
    bus.op_a = 4'd7;  bus.op_b = 4'd12; tick();
    bus.op_valid = 1'b0;
    collect(3, res_q, got);
    check("b2b_count", got, 3);
    check("b2b_res0", res_q[0], 8'h1E);
    check("b2b_res1", res_q[1], 8'h37);
    check("b2b_res2", res_q[2], 8'h54);
    tick(); tick();
    check("b2b_starts", n_starts - s0, 3);
    check("b2b_in_stable", n_in_change - v0, 0);

    // Fill the FIFO against a stalled result: 5 of 6 pairs get in.
    bus.res_accept = 1'b0;
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      if (idx < 6) begin
        bus.op_valid = 1'b1;
        bus.op_a = fill_a[idx];
        bus.op_b = fill_b[idx];
      end else begin
        bus.op_valid = 1'b0;
      end
      if (bus.op_valid && bus.op_ready) begin
        tick();
        idx++;
      end else begin
        tick();
      end
    end
    check("fill_accepted", idx, 5);
    check("fill_op_ready", bus.op_ready, 0);
    check("fill_pending", bus.pending, 4);
    check("fill_hold_data", bus.res_data, 8'h02);
    bus.res_accept = 1'b1;
    tick();
    bus.res_accept = 1'b0;
    check("fill_ready_before_pop", bus.op_ready, 0);
    tick();
    check("fill_ready_after_pop", bus.op_ready, 1);
    check("fill_pending_after_pop", bus.pending, 3);
    tick();
    bus.op_valid = 1'b0;
    check("fill_sixth_pushed", bus.pending, 4);
    bus.res_accept = 1'b1;
    collect(5, res_q, got);
    check("fill_drain_count", got, 5);
    check("fill_res1", res_q[0], 8'h06);
    check("fill_res2", res_q[1], 8'h0C);
    check("fill_res3", res_q[2], 8'h14);
    check("fill_res4", res_q[3], 8'h1E);
    check("fill_res5", res_q[4], 8'h2A);
    tick(); tick();

    // Result backpressure: HOLD stays put and nothing new issues.
    bus.res_accept = 1'b0;
    push(4'd8, 4'd8);
    push(4'd2, 4'd2);
    wait_res("bp_wait");
    s0 = n_starts;
    flag = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!bus.res_valid || bus.res_data != 8'h40) flag = 1'b0;
    end
    check("bp_stable", flag, 1);
    check("bp_no_start", n_starts - s0, 0);
    check("bp_pending", bus.pending, 1);
    bus.res_accept = 1'b1;
    tick();
    wait_res("bp_next_wait");
    check("bp_next_res", bus.res_data, 8'h04);
    tick(); tick();

    // Reset while waiting on the multiplier with two pairs queued.
    push(4'd9, 4'd9);
    push(4'd4, 4'd4);
    push(4'd5, 4'd5);
    for (int t = 0; t < 20 && bus.mul_ready; t++) tick();
    tick(); tick();
    check("mid_pending", bus.pending, 2);
    rst = 1'b0;
    #1;
    check("mid_rst_mul_start", bus.mul_start, 0);
    check("mid_rst_mul_in_1",  bus.mul_in_1, 0);
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_pending",   bus.pending, 0);
    check("mid_rst_op_ready",  bus.op_ready, 1);
    tick(); tick();
    rst = 1'b1;
    s0 = n_starts;
    flag = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.res_valid) flag = 1'b1;
    end
    check("mid_no_result", flag, 0);
    check("mid_no_start", n_starts - s0, 0);
    push(4'd15, 4'd15);
    wait_res("mid_fresh_wait");
    check("mid_fresh_res", bus.res_data, 8'hE1);
    tick(); tick();

    // Product checker: a wrong product sets a sticky err (build dependent).
    corrupt = 1'b1;
    push(4'd3, 4'd3);
    wait_res("err_wait");
    check("err_res_passthru", bus.res_data, 8'h00);
    tick();
    check("err_set", bus.err, ERR_EXP);
    corrupt = 1'b0;
    push(4'd2, 4'd5);
    wait_res("err_next_wait");
    check("err_next_res", bus.res_data, 8'h0A);
    tick();
    check("err_sticky", bus.err, ERR_EXP);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mult_dispatcher.md
Name: mult_dispatcher

Overview:
Upstream operand feeder for the 4x4 sequential multiplier. It buffers operand pairs from a producer in a small FIFO and issues them to the multiplier one at a time. It drives the multiplier's start pulse and operand inputs, waits for completion, and returns each 8-bit product on a valid/accept result handshake. This lets the surrounding system stream operands without tracking the multiplier's multi-cycle busy period.

Parameters:
DEPTH, 4, operand FIFO entries; power of 2, >= 2
PW, 3, width of pending count; equals log2(DEPTH)+1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
op_valid  in  1  producer offers operand pair
op_a  in  4  operand A (unsigned)
op_b  in  4  operand B (unsigned)
op_ready  out  1  FIFO can accept a pair
mul_start  out  1  one-cycle start pulse to multiplier
mul_in_1  out  4  operand A to multiplier
mul_in_2  out  4  operand B to multiplier
mul_out  in  8  multiplier product
mul_ready  in  1  multiplier idle/done flag
res_valid  out  1  result available
res_data  out  8  product
res_accept  in  1  consumer takes result
pending  out  PW  entries currently in FIFO
err  out  1  sticky product-check error; see Optional Feature

Behaviour:
- Reset (rst=0, async): FIFO pointers and count cleared; FSM to IDLE; mul_start=0, mul_in_1=0, mul_in_2=0, res_valid=0, res_data=0, pending=0, err=0. op_ready=1 while rst=0 and on release.
- FIFO:
  - op_ready = (count != DEPTH), combinational from count only.
  - Push on op_valid && op_ready. Pointers wrap modulo DEPTH.
  - Push while full is blocked, even if a pop occurs in the same cycle.
  - Simultaneous push and pop: count unchanged.
  - A pop only consumes entries present before the edge; an entry pushed into an empty FIFO is first poppable on the next cycle.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD.
  - IDLE: if count>0 and mul_ready=1, pop head into mul_in_1/mul_in_2 registers and go to ISSUE. Otherwise stay.
  - ISSUE: mul_start=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: mul_start=0; stay until mul_ready=0, then go to WAIT_DONE.
  - WAIT_DONE: on mul_ready=1, register mul_out into res_data, set res_valid=1, go to HOLD.
  - HOLD: res_valid and res_data stay stable until res_accept=1. On res_accept=1, clear res_valid and go to IDLE.
- mul_in_1/mul_in_2 hold their value from ISSUE until the next pop; they never change while the multiplier is busy.
- Latency: pair pushed at edge 0 into an empty FIFO with an idle multiplier → pop at edge 1, mul_start high in cycle 2, res_valid rises on the edge after mul_ready returns high.
- One operation in flight at a time; results are returned in push order.
- res_accept outside HOLD is ignored.
- Reset asserted mid-operation: all state is discarded immediately; queued pairs are lost; no result is emitted.
- pending = count, registered.
- Arithmetic: none in the datapath; the product is passed through unmodified at 8 bits.

Optional Feature:
- Macro: MULT_DISPATCH_CHECK_EN.
- Defined:
  - In WAIT_DONE, when mul_ready=1, compare mul_out with mul_in_1*mul_in_2 (8-bit unsigned).
  - On mismatch, set err=1. err is sticky and cleared only by reset.
  - res_data still takes mul_out.
- Undefined: no comparator is built; err tied to 0.

Test Plan:
- Bench multiplier model for all scenarios: mul_ready drops the cycle after mul_start and rises 6 cycles later with the product.
- Reset release, single pair 6,9 with res_accept=1 → mul_start pulses once; mul_in_1=6, mul_in_2=9; res_valid=1 with res_data=0x36; pending returns to 0.
- Push 10,3 / 11,5 / 7,12 back-to-back, res_accept held 1 → exactly 3 mul_start pulses; results 0x1E, 0x37, 0x54 in order; mul_in never changes while mul_ready=0.
- DEPTH=4, res_accept=0, op_valid held high with 6 pairs → exactly 5 pairs accepted; then op_ready=0 and pending=4. Assert res_accept → op_ready=1 one cycle after the next pop.
- Result backpressure: res_accept=0 for 10 cycles in HOLD → res_valid and res_data stable; no new mul_start until the accept.
- Assert rst low while in WAIT_DONE with 2 entries queued → outputs immediately at reset values; no res_valid after release; a fresh pair 15,15 gives 0xE1.
- With MULT_DISPATCH_CHECK_EN, force the model to return 0x00 for 3,3 → err=1 and stays 1 across later correct results; without the macro, err=0 throughout.
